// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem read port and
// produces the IF/ID register, with a sticky fetch-error flag and performance counters.
module fetch_unit #(
  parameter int unsigned AW         = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int unsigned IMEM_BYTES = 4096,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pc_src,
  input  logic [AW-1:0]    jump_target,
  input  logic [AW-1:0]    branch_target,
  input  logic             if_id_stall,
  input  logic             if_id_flush,
  output logic             imem_en,
  output logic [AW-1:0]    imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      id_instr,
  output logic [AW-1:0]    id_pc,
  output logic [AW-1:0]    id_pc_plus4,
  output logic             id_valid,
  output logic             fetch_error,
  output logic [CNT_W-1:0] cnt_fetch,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_stall
);

  localparam logic [1:0] PCS_JPA = 2'b01;
  localparam logic [1:0] PCS_BRA = 2'b10;

  logic [AW-1:0]    pc_q, pc_d;
  logic             err_q, err_d;
  logic [31:0]      instr_q;
  logic [AW-1:0]    id_pc_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_fetch_q, cnt_flush_q, cnt_stall_q;
  logic             redirect;
  logic             load_valid;

  always_comb begin
    redirect = 1'b0;
    if (rst) begin
      pc_d = RESET_PC;
    end else if (pc_src == PCS_BRA) begin
      pc_d     = branch_target;
      redirect = 1'b1;
    end else if (pc_src == PCS_JPA) begin
      pc_d     = jump_target;
      redirect = 1'b1;
    end else if (if_id_stall || err_q) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + AW'(4);
    end
  end

  // Error is judged on the address about to be fetched; it stays set until reset.
  always_comb begin
    err_d = err_q;
    if (rst) begin
      err_d = 1'b0;
    end else if ((redirect && (pc_d[1:0] != 2'b00)) || (pc_d >= AW'(IMEM_BYTES))) begin
      err_d = 1'b1;
    end
  end

  assign load_valid = !rst && !if_id_flush && !if_id_stall && !err_q;

  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    err_q <= err_d;
    if (rst) begin
      instr_q <= NOP_INSTR;
      id_pc_q <= RESET_PC;
      valid_q <= 1'b0;
    end else if (if_id_flush) begin
      instr_q <= NOP_INSTR;
      id_pc_q <= pc_q;
      valid_q <= 1'b0;
    end else if (if_id_stall) begin
      instr_q <= instr_q;
      id_pc_q <= id_pc_q;
      valid_q <= valid_q;
    end else if (err_q) begin
      instr_q <= NOP_INSTR;
      id_pc_q <= pc_q;
      valid_q <= 1'b0;
    end else begin
      instr_q <= imem_rdata;
      id_pc_q <= pc_q;
      valid_q <= 1'b1;
    end
  end

  // Saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_fetch_q <= '0;
      cnt_flush_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      if (load_valid && (cnt_fetch_q != '1)) cnt_fetch_q <= cnt_fetch_q + CNT_W'(1);
      if (if_id_flush && (cnt_flush_q != '1)) cnt_flush_q <= cnt_flush_q + CNT_W'(1);
      if (if_id_stall && !if_id_flush && (cnt_stall_q != '1)) begin
        cnt_stall_q <= cnt_stall_q + CNT_W'(1);
      end
    end
  end

  assign imem_addr   = pc_d;
  assign imem_en     = !err_q;
  assign id_instr    = instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_q + AW'(4);
  assign id_valid    = valid_q;
  assign fetch_error = err_q;
  assign cnt_fetch   = cnt_fetch_q;
  assign cnt_flush   = cnt_flush_q;
  assign cnt_stall   = cnt_stall_q;

endmodule
